check_done: RTL and testbench

CHECK_DONE -- requirements
Module: check_done

---
 rtl/check_done_pkg.sv | 19 +
 rtl/check_done.sv | 65 ++++++
 tb/tb_check_done.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/check_done_pkg.sv
// Shared widths, default map size, tile codes and sweep-tracker payload for the pellet-completion monitor.
package check_done_pkg;

    localparam int unsigned ADDR_W        = 10;
    localparam int unsigned TILE_W        = 4;
    localparam int unsigned MAP_TILES_DEF = 768;

    localparam logic [TILE_W-1:0] TILE_EMPTY  = 4'd0;
    localparam logic [TILE_W-1:0] TILE_WALL   = 4'd1;
    localparam logic [TILE_W-1:0] TILE_PELLET = 4'd2;
    localparam logic [TILE_W-1:0] TILE_POWER  = 4'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] prev_addr;
        logic              sweep_valid;
        logic              pellet_seen;
    } sweep_t;

endpackage

// File: rtl/check_done.sv
// Passive monitor of the display scanner's map reads; flags game_over once a clean,
// contiguous sweep from tile 0 to the last tile finds no pellet.
module check_done
    import check_done_pkg::*;
#(
    parameter int unsigned       MAP_TILES   = MAP_TILES_DEF,
    parameter logic [TILE_W-1:0] PELLET_CODE = TILE_PELLET,
    parameter logic [TILE_W-1:0] POWER_CODE  = TILE_POWER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic [TILE_W-1:0] read_data,
    output logic              game_over
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_TILES - 1);

    logic   is_pellet_c;
    logic   in_range_c;
    logic   start_c;
    logic   contig_c;
    sweep_t trk_q, trk_d;
    logic   game_over_q, game_over_d;

    assign is_pellet_c = (read_data == PELLET_CODE) || (read_data == POWER_CODE);
    assign in_range_c  = 32'(read_addr) < MAP_TILES;
    assign start_c     = (read_addr == '0);
    assign contig_c    = (read_addr == trk_q.prev_addr) ||
                         (read_addr == trk_q.prev_addr + ADDR_W'(1));

    // Sweep tracking and end-of-sweep evaluation; off-map reads leave everything untouched.
    always_comb begin
        trk_d       = trk_q;
        game_over_d = game_over_q;
        if (in_range_c) begin
            trk_d.prev_addr = read_addr;
            if (start_c) begin
                trk_d.sweep_valid = 1'b1;
                trk_d.pellet_seen = is_pellet_c;
            end else if (trk_q.sweep_valid && contig_c) begin
                trk_d.pellet_seen = trk_q.pellet_seen | is_pellet_c;
            end else begin
                trk_d.sweep_valid = 1'b0;
            end
            // trk_d already folds in the current tile and this cycle's continuity.
            if ((read_addr == LAST_ADDR) && trk_d.sweep_valid && !trk_d.pellet_seen) begin
                game_over_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            trk_q       <= '0;
            game_over_q <= 1'b0;
        end else begin
            trk_q       <= trk_d;
            game_over_q <= game_over_d;
        end
    end

    assign game_over = game_over_q;

endmodule

// File: tb/tb_check_done.sv
// Bench for check_done: table of sweep scenarios plus hand-written reset corner sequences,
// with a one-deep scoreboard of expected game_over values popped after each clock edge.
module tb_check_done;

    logic       clk;
    logic       reset;
    logic [9:0] read_addr;
    logic [3:0] read_data;
    logic       game_over;

    int n_tests;
    int n_fail;
    bit cur_go;

    typedef struct {
        string name;
        logic  exp;
    } sb_t;

    sb_t sb_q[$];

    typedef struct {
        string      name;
        bit         rst_first;
        int         pel_addr;
        logic [3:0] pel_code;
        int         jump_at;
        int         hold;
        bit         inter;
        bit         exp;
    } vec_t;

    vec_t vecs[11];

    check_done dut (
        .clk       (clk),
        .reset     (reset),
        .read_addr (read_addr),
        .read_data (read_data),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [9:0] a, input logic [3:0] d, input logic rn,
                        input logic exp_go, input string nm);
        sb_t e;
        read_addr = a;
        read_data = d;
        reset     = rn;
        sb_q.push_back('{nm, exp_go});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_tests++;
        if (game_over !== e.exp) begin
            n_fail++;
            $display("FAIL %s: addr=%0d game_over=%b expected=%b", e.name, a, game_over, e.exp);
        end
    endtask

    task automatic run_sweep(input vec_t v);
        bit pre;
        bit seen_last;
        logic [3:0] d;
        pre = cur_go;
        seen_last = 1'b0;
        if (v.rst_first) begin
            step(10'd0, 4'd0, 1'b0, 1'b0, {v.name, "_reset"});
            pre = 1'b0;
        end
        for (int a = 0; a < 768; a++) begin
            if (v.jump_at >= 0 && a > v.jump_at && a < 600) continue;
            d = (a == v.pel_addr) ? v.pel_code : 4'd0;
            for (int h = 0; h < v.hold; h++) begin
                if (a == 767) seen_last = 1'b1;
                step(10'(a), d, 1'b1, seen_last ? v.exp : pre, v.name);
                if (v.inter && h == 1)
                    step(10'(800 + (a % 224)), 4'd2, 1'b1, seen_last ? v.exp : pre,
                         {v.name, "_offmap"});
            end
        end
        cur_go = v.exp;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cur_go    = 1'b0;
        reset     = 1'b0;
        read_addr = '0;
        read_data = '0;

        vecs[0]  = '{"empty_sweep",        1'b1,  -1, 4'd0, -1,  1, 1'b0, 1'b1};
        vecs[1]  = '{"sticky_pellet",      1'b0,   5, 4'd2, -1,  1, 1'b0, 1'b1};
        vecs[2]  = '{"pellet765",          1'b1, 765, 4'd2, -1,  1, 1'b0, 1'b0};
        vecs[3]  = '{"empty_after_pellet", 1'b0,  -1, 4'd0, -1,  1, 1'b0, 1'b1};
        vecs[4]  = '{"jump400_600",        1'b1,  -1, 4'd0, 400, 1, 1'b0, 1'b0};
        vecs[5]  = '{"clean_after_jump",   1'b0,  -1, 4'd0, -1,  1, 1'b0, 1'b1};
        vecs[6]  = '{"power_at_0",         1'b1,   0, 4'd3, -1,  1, 1'b0, 1'b0};
        vecs[7]  = '{"pellet_at_767",      1'b0, 767, 4'd2, -1,  1, 1'b0, 1'b0};
        vecs[8]  = '{"empty_final",        1'b0,  -1, 4'd0, -1,  1, 1'b0, 1'b1};
        vecs[9]  = '{"held4_offmap",       1'b1,  -1, 4'd0, -1,  4, 1'b1, 1'b1};
        vecs[10] = '{"held4_power10",      1'b1,  10, 4'd3, -1,  4, 1'b1, 1'b0};

        // Reset state, then a tail of a sweep with no addr-0 start.
        step(10'd0, 4'd0, 1'b0, 1'b0, "reset_state");
        step(10'd764, 4'd0, 1'b1, 1'b0, "nostart_764");
        step(10'd765, 4'd2, 1'b1, 1'b0, "nostart_765");
        step(10'd766, 4'd0, 1'b1, 1'b0, "nostart_766");
        step(10'd767, 4'd0, 1'b1, 1'b0, "nostart_767");
        step(10'd767, 4'd0, 1'b1, 1'b0, "nostart_767_hold");

        foreach (vecs[i]) run_sweep(vecs[i]);

        // Reset coincident with the final-tile sample of an empty sweep.
        step(10'd0, 4'd0, 1'b0, 1'b0, "rst_final_pre");
        for (int a = 0; a < 767; a++) step(10'(a), 4'd0, 1'b1, 1'b0, "rst_final_sweep");
        step(10'd767, 4'd0, 1'b0, 1'b0, "rst_on_final");
        step(10'd767, 4'd0, 1'b1, 1'b0, "after_rst_on_final");
        cur_go = 1'b0;

        // Set game_over, then reset clears it in one cycle.
        run_sweep(vecs[8]);
        step(10'd0, 4'd0, 1'b0, 1'b0, "rst_clears_go");
        step(10'd5, 4'd0, 1'b1, 1'b0, "go_stays_clear");

        // Reset mid-sweep discards the sweep.
        step(10'd0, 4'd0, 1'b1, 1'b0, "mid_rst_start");
        for (int a = 1; a <= 300; a++) step(10'(a), 4'd0, 1'b1, 1'b0, "mid_rst_sweep");
        step(10'd300, 4'd0, 1'b0, 1'b0, "mid_rst_pulse");
        for (int a = 301; a < 768; a++) step(10'(a), 4'd0, 1'b1, 1'b0, "mid_rst_rest");
        step(10'd767, 4'd0, 1'b1, 1'b0, "mid_rst_hold");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
